// File: rtl/ledge_bank_if.sv
// Configuration bus from the game-state controller into the ledge bank.
// The controller drives through the master modport; the ledge bank samples
// through the slave modport.
interface ledge_bank_if;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic       cfg_valid;
    logic [9:0] cfg_x;
    logic [9:0] cfg_y;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_range;
    logic [3:0] cfg_speed;

    modport master (
        output cfg_we, cfg_idx, cfg_valid, cfg_x, cfg_y,
               cfg_mode, cfg_range, cfg_speed
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_valid, cfg_x, cfg_y,
               cfg_mode, cfg_range, cfg_speed
    );
endinterface

// File: rtl/ledge_bank.sv
// Bank of NUM_LEDGES platforms. Each is static or patrols along X or Y,
// stepping once per frame. Provides a registered per-pixel draw hit and a
// registered landing query (surface top and carry velocity) for the fighter.
module ledge_bank #(
    parameter int unsigned NUM_LEDGES = 4,
    parameter logic [9:0]  HALF_W     = 10'd67,
    parameter logic [9:0]  HALF_H     = 10'd12,
    parameter logic [9:0]  LAND_TOL   = 10'd4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    ledge_bank_if.slave cfg,
    input  logic [9:0] query_x,
    input  logic [9:0] query_y,
    output logic       is_ledge,
    output logic [2:0] ledge_idx,
    output logic       land_hit,
    output logic [9:0] land_top_y,
    output logic [4:0] land_dx,
    output logic [4:0] land_dy
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_HORIZ  = 2'd1,
        MODE_VERT   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    localparam logic signed [12:0] HW13  = {3'b000, HALF_W};
    localparam logic signed [12:0] HH13  = {3'b000, HALF_H};
    localparam logic signed [12:0] TOL13 = {3'b000, LAND_TOL};

    // Clamp a signed intermediate into the 10-bit screen range.
    function automatic logic [9:0] sat10(input logic signed [12:0] v);
        if (v < 0)
            return '0;
        else if (v > 13'sd1023)
            return '1;
        else
            return v[9:0];
    endfunction

    // frame strobe synchroniser
    logic fc_meta, fc_sync, fc_prev, frame_tick;

    // per-slot registered state
    logic              slot_valid  [NUM_LEDGES];
    logic [9:0]        slot_base_x [NUM_LEDGES];
    logic [9:0]        slot_base_y [NUM_LEDGES];
    mode_e             slot_mode   [NUM_LEDGES];
    logic [7:0]        slot_range  [NUM_LEDGES];
    logic [3:0]        slot_speed  [NUM_LEDGES];
    logic signed [10:0] slot_off   [NUM_LEDGES];
    dir_e              slot_dir    [NUM_LEDGES];
    logic signed [4:0] slot_step   [NUM_LEDGES];

    // next values should a frame tick land this cycle
    logic              moving      [NUM_LEDGES];
    logic signed [10:0] step_off   [NUM_LEDGES];
    dir_e              step_dir    [NUM_LEDGES];
    logic signed [4:0] step_delta  [NUM_LEDGES];

    // saturated bounds of each slot's current position
    logic [9:0] b_left  [NUM_LEDGES];
    logic [9:0] b_right [NUM_LEDGES];
    logic [9:0] b_top   [NUM_LEDGES];
    logic [9:0] b_bot   [NUM_LEDGES];
    logic [9:0] b_land  [NUM_LEDGES];

    // combinational hit results ahead of the output registers
    logic       draw_hit_c;
    logic [2:0] draw_idx_c;
    logic       land_hit_c;
    logic [9:0] land_top_c;
    logic [4:0] land_dx_c;
    logic [4:0] land_dy_c;

    // Two-flop synchroniser plus rising-edge detect gives a one-cycle frame_tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_meta    <= 1'b0;
            fc_sync    <= 1'b0;
            fc_prev    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            fc_meta    <= frame_clk;
            fc_sync    <= fc_meta;
            fc_prev    <= fc_sync;
            frame_tick <= fc_sync & ~fc_prev;
        end
    end

    // Per-slot patrol step: advance by speed, clamp at +/-range and reverse.
    always_comb begin
        logic signed [11:0] off_w;
        logic signed [11:0] spd_w;
        logic signed [11:0] rng_w;
        logic signed [11:0] nxt_w;
        logic signed [11:0] lim_w;
        logic               at_end;
        off_w  = '0;
        spd_w  = '0;
        rng_w  = '0;
        nxt_w  = '0;
        lim_w  = '0;
        at_end = 1'b0;
        for (int unsigned i = 0; i < NUM_LEDGES; i++) begin
            moving[i]     = slot_valid[i]
                          && (slot_mode[i] == MODE_HORIZ || slot_mode[i] == MODE_VERT)
                          && (slot_range[i] != '0) && (slot_speed[i] != '0);
            step_off[i]   = '0;
            step_dir[i]   = slot_dir[i];
            step_delta[i] = '0;

            off_w = {slot_off[i][10], slot_off[i]};
            spd_w = {8'b0, slot_speed[i]};
            rng_w = {4'b0, slot_range[i]};
            if (slot_dir[i] == DIR_POS) begin
                nxt_w  = off_w + spd_w;
                lim_w  = rng_w;
                at_end = (nxt_w >= rng_w);
            end else begin
                nxt_w  = off_w - spd_w;
                lim_w  = -rng_w;
                at_end = (nxt_w <= -rng_w);
            end

            if (moving[i]) begin
                if (at_end) begin
                    step_off[i]   = 11'(lim_w);
                    step_dir[i]   = (slot_dir[i] == DIR_POS) ? DIR_NEG : DIR_POS;
                    step_delta[i] = 5'(lim_w - off_w);
                end else begin
                    step_off[i]   = 11'(nxt_w);
                    step_delta[i] = 5'(nxt_w - off_w);
                end
            end
        end
    end

    // Slot state: config writes take priority over a frame step for their slot.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_LEDGES; i++) begin
                slot_valid[i]  <= 1'b0;
                slot_base_x[i] <= '0;
                slot_base_y[i] <= '0;
                slot_mode[i]   <= MODE_STATIC;
                slot_range[i]  <= '0;
                slot_speed[i]  <= '0;
                slot_off[i]    <= '0;
                slot_dir[i]    <= DIR_POS;
                slot_step[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_LEDGES; i++) begin
                if (cfg.cfg_we && cfg.cfg_idx == 3'(i)) begin
                    slot_valid[i]  <= cfg.cfg_valid;
                    slot_base_x[i] <= cfg.cfg_x;
                    slot_base_y[i] <= cfg.cfg_y;
                    slot_mode[i]   <= mode_e'(cfg.cfg_mode);
                    slot_range[i]  <= cfg.cfg_range;
                    slot_speed[i]  <= cfg.cfg_speed;
                    slot_off[i]    <= '0;
                    slot_dir[i]    <= DIR_POS;
                    slot_step[i]   <= '0;
                end else if (frame_tick) begin
                    slot_off[i]    <= step_off[i];
                    slot_dir[i]    <= step_dir[i];
                    slot_step[i]   <= step_delta[i];
                end
            end
        end
    end

    // Current centre from base plus patrol offset, then saturated bounds.
    always_comb begin
        logic signed [12:0] cx;
        logic signed [12:0] cy;
        cx = '0;
        cy = '0;
        for (int unsigned i = 0; i < NUM_LEDGES; i++) begin
            cx = {3'b000, slot_base_x[i]};
            cy = {3'b000, slot_base_y[i]};
            if (slot_mode[i] == MODE_HORIZ)
                cx = cx + {{2{slot_off[i][10]}}, slot_off[i]};
            if (slot_mode[i] == MODE_VERT)
                cy = cy + {{2{slot_off[i][10]}}, slot_off[i]};
            b_left[i]  = sat10(cx - HW13);
            b_right[i] = sat10(cx + HW13);
            b_top[i]   = sat10(cy - HH13);
            b_bot[i]   = sat10(cy + HH13);
            // landing window is measured from the already-saturated top
            b_land[i]  = sat10({3'b000, b_top[i]} + TOL13);
        end
    end

    // Priority search: lowest valid index wins for both draw and landing.
    always_comb begin
        draw_hit_c = 1'b0;
        draw_idx_c = '0;
        land_hit_c = 1'b0;
        land_top_c = '0;
        land_dx_c  = '0;
        land_dy_c  = '0;
        for (int unsigned i = 0; i < NUM_LEDGES; i++) begin
            if (!draw_hit_c && slot_valid[i]
                && DrawX >= b_left[i] && DrawX <= b_right[i]
                && DrawY >= b_top[i]  && DrawY <= b_bot[i]) begin
                draw_hit_c = 1'b1;
                draw_idx_c = 3'(i);
            end
            if (!land_hit_c && slot_valid[i]
                && query_x >= b_left[i] && query_x <= b_right[i]
                && query_y >= b_top[i]  && query_y <= b_land[i]) begin
                land_hit_c = 1'b1;
                land_top_c = b_top[i];
                if (slot_mode[i] == MODE_HORIZ)
                    land_dx_c = slot_step[i];
                if (slot_mode[i] == MODE_VERT)
                    land_dy_c = slot_step[i];
            end
        end
    end

    // Output registers: one-cycle latency from pixel/query inputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            is_ledge   <= 1'b0;
            ledge_idx  <= '0;
            land_hit   <= 1'b0;
            land_top_y <= '0;
            land_dx    <= '0;
            land_dy    <= '0;
        end else begin
            is_ledge   <= draw_hit_c;
            ledge_idx  <= draw_idx_c;
            land_hit   <= land_hit_c;
            land_top_y <= land_top_c;
            land_dx    <= land_dx_c;
            land_dy    <= land_dy_c;
        end
    end

endmodule

// File: tb/tb_ledge_bank.sv
// Self-checking bench for ledge_bank: a behavioural slot model checked every
// cycle, a table of static-ledge vectors, and directed multi-cycle sequences.
module tb_ledge_bank;
    localparam int N = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [9:0] DrawX, DrawY, query_x, query_y;
    logic       is_ledge;
    logic [2:0] ledge_idx;
    logic       land_hit;
    logic [9:0] land_top_y;
    logic [4:0] land_dx, land_dy;

    ledge_bank_if cfg_bus();

    ledge_bank #(
        .NUM_LEDGES(N),
        .HALF_W    (10'd67),
        .HALF_H    (10'd12),
        .LAND_TOL  (10'd4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .cfg       (cfg_bus),
        .query_x   (query_x),
        .query_y   (query_y),
        .is_ledge  (is_ledge),
        .ledge_idx (ledge_idx),
        .land_hit  (land_hit),
        .land_top_y(land_top_y),
        .land_dx   (land_dx),
        .land_dy   (land_dy)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit valid;
        int bx, by, mode, range, speed;
        int off, dir, step;
    } slot_t;

    slot_t m [N];
    int    h [4];   // frame_clk samples at the last four edges, newest first

    typedef struct {
        int dx, dy, qx, qy;
        int e_is, e_idx, e_hit, e_top;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    function automatic int cen_x(input slot_t s);
        return s.bx + ((s.mode == 1) ? s.off : 0);
    endfunction

    function automatic int cen_y(input slot_t s);
        return s.by + ((s.mode == 2) ? s.off : 0);
    endfunction

    // Expected registered outputs from the model's present slot state.
    task automatic model_out(output int e_is, output int e_idx, output int e_hit,
                             output int e_top, output int e_dx, output int e_dy);
        int l, r, t, b, lt;
        e_is = 0; e_idx = 0; e_hit = 0; e_top = 0; e_dx = 0; e_dy = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i].valid) begin
                l  = sat(cen_x(m[i]) - 67);
                r  = sat(cen_x(m[i]) + 67);
                t  = sat(cen_y(m[i]) - 12);
                b  = sat(cen_y(m[i]) + 12);
                lt = sat(t + 4);
                if (e_is == 0 && DrawX >= l && DrawX <= r && DrawY >= t && DrawY <= b) begin
                    e_is = 1; e_idx = i;
                end
                if (e_hit == 0 && query_x >= l && query_x <= r && query_y >= t && query_y <= lt) begin
                    e_hit = 1; e_top = t;
                    e_dx = (m[i].mode == 1) ? m[i].step : 0;
                    e_dy = (m[i].mode == 2) ? m[i].step : 0;
                end
            end
        end
    endtask

    // One clock: predict, advance the model, then compare every output.
    task automatic cyc();
        int    e_is, e_idx, e_hit, e_top, e_dx, e_dy, nxt;
        bit    tick;
        slot_t nx [N];
        if (Reset) begin
            e_is = 0; e_idx = 0; e_hit = 0; e_top = 0; e_dx = 0; e_dy = 0;
            for (int i = 0; i < N; i++) begin
                nx[i] = '{default: 0};
                nx[i].dir = 1;
            end
        end else begin
            model_out(e_is, e_idx, e_hit, e_top, e_dx, e_dy);
            tick = (h[2] == 1 && h[3] == 0);
            for (int i = 0; i < N; i++) begin
                nx[i] = m[i];
                if (cfg_bus.cfg_we && cfg_bus.cfg_idx == i) begin
                    nx[i].valid = cfg_bus.cfg_valid;
                    nx[i].bx    = cfg_bus.cfg_x;
                    nx[i].by    = cfg_bus.cfg_y;
                    nx[i].mode  = cfg_bus.cfg_mode;
                    nx[i].range = cfg_bus.cfg_range;
                    nx[i].speed = cfg_bus.cfg_speed;
                    nx[i].off   = 0;
                    nx[i].dir   = 1;
                    nx[i].step  = 0;
                end else if (tick) begin
                    if (m[i].valid && (m[i].mode == 1 || m[i].mode == 2)
                        && m[i].range > 0 && m[i].speed > 0) begin
                        nxt = m[i].off + m[i].dir * m[i].speed;
                        if (nxt >= m[i].range || nxt <= -m[i].range) begin
                            nx[i].off = m[i].dir * m[i].range;
                            nx[i].dir = -m[i].dir;
                        end else begin
                            nx[i].off = nxt;
                        end
                        nx[i].step = nx[i].off - m[i].off;
                    end else begin
                        nx[i].off  = 0;
                        nx[i].step = 0;
                    end
                end
            end
        end
        if (Reset) begin
            for (int i = 0; i < 4; i++) h[i] = 0;
        end else begin
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = int'(frame_clk);
        end
        @(posedge Clk);
        #1;
        for (int i = 0; i < N; i++) m[i] = nx[i];
        chk("model_is_ledge",   int'(is_ledge),             e_is);
        chk("model_ledge_idx",  int'(ledge_idx),            e_idx);
        chk("model_land_hit",   int'(land_hit),             e_hit);
        chk("model_land_top_y", int'(land_top_y),           e_top);
        chk("model_land_dx",    int'($signed(land_dx)),     e_dx);
        chk("model_land_dy",    int'($signed(land_dy)),     e_dy);
    endtask

    task automatic wr(input int idx, input int v, input int x, input int y,
                      input int mode, input int range, input int speed);
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_idx   = 3'(idx);
        cfg_bus.cfg_valid = v[0];
        cfg_bus.cfg_x     = 10'(x);
        cfg_bus.cfg_y     = 10'(y);
        cfg_bus.cfg_mode  = 2'(mode);
        cfg_bus.cfg_range = 8'(range);
        cfg_bus.cfg_speed = 4'(speed);
        cyc();
        cfg_bus.cfg_we    = 1'b0;
    endtask

    task automatic pulse();
        frame_clk = 1'b1;
        repeat (2) cyc();
        frame_clk = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic set_px(input int dx, input int dy, input int qx, input int qy);
        DrawX = 10'(dx); DrawY = 10'(dy); query_x = 10'(qx); query_y = 10'(qy);
    endtask

    initial begin
        vec_t vt [8];
        int   exp_c [5];
        int   exp_s [5];
        int   fc_hold, j, cx, cy;

        vt[0] = '{253, 400, 320, 388, 1, 0, 1, 388};
        vt[1] = '{387, 400, 320, 392, 1, 0, 1, 388};
        vt[2] = '{252, 400, 320, 393, 0, 0, 0, 0};
        vt[3] = '{388, 400, 320, 387, 0, 0, 0, 0};
        vt[4] = '{320, 388, 253, 390, 1, 0, 1, 388};
        vt[5] = '{320, 412, 252, 390, 1, 0, 0, 0};
        vt[6] = '{320, 413, 387, 388, 0, 0, 1, 388};
        vt[7] = '{320, 387, 388, 388, 0, 0, 0, 0};
        exp_c = '{204, 208, 210, 206, 202};
        exp_s = '{4, 4, 2, -4, -4};

        Reset = 1'b1; frame_clk = 1'b0;
        set_px(0, 0, 0, 0);
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_idx = '0; cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_x = '0; cfg_bus.cfg_y = '0; cfg_bus.cfg_mode = '0;
        cfg_bus.cfg_range = '0; cfg_bus.cfg_speed = '0;
        for (int i = 0; i < 4; i++) h[i] = 0;
        for (int i = 0; i < N; i++) begin
            m[i] = '{default: 0};
            m[i].dir = 1;
        end
        repeat (2) cyc();
        chk("reset_is_ledge", int'(is_ledge), 0);
        chk("reset_land_hit", int'(land_hit), 0);
        Reset = 1'b0;
        cyc();

        // static ledge at (320,400): table of edge vectors
        wr(0, 1, 320, 400, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            set_px(vt[k].dx, vt[k].dy, vt[k].qx, vt[k].qy);
            cyc();
            chk($sformatf("vec%0d_is_ledge", k),   int'(is_ledge),   vt[k].e_is);
            chk($sformatf("vec%0d_ledge_idx", k),  int'(ledge_idx),  vt[k].e_idx);
            chk($sformatf("vec%0d_land_hit", k),   int'(land_hit),   vt[k].e_hit);
            chk($sformatf("vec%0d_land_top_y", k), int'(land_top_y), vt[k].e_top);
        end

        // one-cycle latency: output still reflects the previous pixel
        set_px(253, 400, 0, 0);
        #2;
        chk("latency_before_edge", int'(is_ledge), 0);
        cyc();
        chk("latency_after_edge", int'(is_ledge), 1);

        // horizontal patrol with clamp and reversal
        wr(1, 1, 200, 100, 1, 10, 4);
        for (int k = 0; k < 5; k++) begin
            pulse();
            set_px(exp_c[k] - 67, 100, 200, 88);
            cyc();
            chk($sformatf("patrol%0d_left_hit", k), int'(is_ledge), 1);
            chk($sformatf("patrol%0d_idx", k),      int'(ledge_idx), 1);
            chk($sformatf("patrol%0d_land", k),     int'(land_hit), 1);
            chk($sformatf("patrol%0d_top", k),      int'(land_top_y), 88);
            chk($sformatf("patrol%0d_dx", k),       int'($signed(land_dx)), exp_s[k]);
            chk($sformatf("patrol%0d_dy", k),       int'($signed(land_dy)), 0);
            set_px(exp_c[k] - 68, 100, 200, 88);
            cyc();
            chk($sformatf("patrol%0d_left_miss", k), int'(is_ledge), 0);
        end

        // overlap priority
        set_px(320, 400, 0, 0);
        wr(2, 1, 320, 400, 0, 0, 0);
        cyc();
        chk("overlap_idx0", int'(ledge_idx), 0);
        chk("overlap_hit0", int'(is_ledge), 1);
        wr(0, 0, 320, 400, 0, 0, 0);
        cyc();
        chk("overlap_idx2", int'(ledge_idx), 2);
        chk("overlap_hit2", int'(is_ledge), 1);

        // bound saturation at both screen edges
        wr(2, 1, 30, 600, 0, 0, 0);
        wr(3, 1, 1000, 700, 0, 0, 0);
        set_px(0, 600, 0, 0);    cyc();
        chk("sat_left_hit", int'(is_ledge), 1);
        chk("sat_left_idx", int'(ledge_idx), 2);
        set_px(1023, 700, 0, 0); cyc();
        chk("sat_right_hit", int'(is_ledge), 1);
        chk("sat_right_idx", int'(ledge_idx), 3);
        set_px(5, 700, 0, 0);    cyc();
        chk("sat_no_wrap", int'(is_ledge), 0);
        set_px(932, 700, 0, 0);  cyc();
        chk("sat_right_left_edge", int'(is_ledge), 0);

        // out-of-range slot index is ignored
        wr(5, 1, 320, 100, 0, 0, 0);
        set_px(320, 100, 0, 0); cyc();
        chk("ignored_write", int'(is_ledge), 0);

        // config write coincident with frame_tick
        wr(3, 1, 600, 300, 2, 20, 3);
        frame_clk = 1'b1;
        repeat (3) cyc();
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_idx = 3'd1; cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_x = 10'd200; cfg_bus.cfg_y = 10'd100; cfg_bus.cfg_mode = 2'd1;
        cfg_bus.cfg_range = 8'd10; cfg_bus.cfg_speed = 4'd4;
        cyc();
        cfg_bus.cfg_we = 1'b0;
        repeat (4) cyc();
        frame_clk = 1'b0;
        repeat (4) cyc();
        set_px(133, 100, 200, 88); cyc();
        chk("coinc_slot1_hit", int'(is_ledge), 1);
        chk("coinc_slot1_dx", int'($signed(land_dx)), 0);
        set_px(132, 100, 600, 291); cyc();
        chk("coinc_slot1_miss", int'(is_ledge), 0);
        chk("coinc_slot3_land", int'(land_hit), 1);
        chk("coinc_slot3_top", int'(land_top_y), 291);
        chk("coinc_slot3_dy", int'($signed(land_dy)), 3);

        // reset in the middle of a patrol
        pulse();
        set_px(600, 300, 200, 88);
        Reset = 1'b1; cyc();
        chk("midreset_is_ledge", int'(is_ledge), 0);
        chk("midreset_land_hit", int'(land_hit), 0);
        chk("midreset_top", int'(land_top_y), 0);
        Reset = 1'b0; cyc();
        chk("postreset_is_ledge", int'(is_ledge), 0);
        chk("postreset_land_hit", int'(land_hit), 0);

        // randomized traffic against the model
        fc_hold = 3;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 399) == 0) Reset = 1'b1;
            else Reset = 1'b0;
            if (fc_hold == 0) begin
                frame_clk = ~frame_clk;
                fc_hold = int'($urandom_range(1, 6));
            end else begin
                fc_hold--;
            end
            if ($urandom_range(0, 11) == 0) begin
                cfg_bus.cfg_we    = 1'b1;
                cfg_bus.cfg_idx   = 3'($urandom_range(0, 7));
                cfg_bus.cfg_valid = ($urandom_range(0, 3) != 0);
                cfg_bus.cfg_x     = 10'($urandom_range(80, 940));
                cfg_bus.cfg_y     = 10'($urandom_range(30, 990));
                cfg_bus.cfg_mode  = 2'($urandom_range(0, 3));
                cfg_bus.cfg_range = 8'($urandom_range(0, 60));
                cfg_bus.cfg_speed = 4'($urandom_range(0, 15));
            end else begin
                cfg_bus.cfg_we = 1'b0;
            end
            j  = int'($urandom_range(0, N - 1));
            cx = cen_x(m[j]);
            cy = cen_y(m[j]);
            set_px(sat(cx + int'($urandom_range(0, 160)) - 80),
                   sat(cy + int'($urandom_range(0, 40)) - 20),
                   sat(cx + int'($urandom_range(0, 160)) - 80),
                   sat(sat(cy - 12) + int'($urandom_range(0, 8)) - 2));
            cyc();
        end
        Reset = 1'b0;
        cfg_bus.cfg_we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ledge_bank.md
Name: ledge_bank

Overview:
- Parametrised successor to the single static ledge. Holds NUM_LEDGES independently configurable platforms; each is static or patrols horizontally/vertically, stepping once per frame.
- Provides a registered per-pixel draw hit with the index of the ledge hit, for the colour mapper.
- Provides a registered landing query for the fighter physics: surface top Y and the ledge's carry velocity.
- Sits between the game-state controller (config writes) and the fighter/colour-mapper logic.

Parameters:
- NUM_LEDGES, 4, number of ledge slots (1..8).
- HALF_W, 10'd67, half width in pixels.
- HALF_H, 10'd12, half height in pixels.
- LAND_TOL, 10'd4, pixels below the top surface that still count as landed.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  vsync-rate strobe, asynchronous to game logic.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- cfg_we  in  1  config write strobe.
- cfg_idx  in  3  slot written.
- cfg_valid  in  1  slot enabled.
- cfg_x  in  10  base centre X.
- cfg_y  in  10  base centre Y.
- cfg_mode  in  2  0 static, 1 horizontal patrol, 2 vertical patrol, 3 reserved (treated as static).
- cfg_range  in  8  max |offset| from base.
- cfg_speed  in  4  pixels per frame.
- query_x  in  10  fighter foot X.
- query_y  in  10  fighter foot Y.
- is_ledge  out  1  pixel lies on an enabled ledge.
- ledge_idx  out  3  lowest-index ledge hit.
- land_hit  out  1  query point is on a ledge top.
- land_top_y  out  10  top surface Y (centre Y − HALF_H) of the landed ledge.
- land_dx  out  5  signed X carry for the last frame.
- land_dy  out  5  signed Y carry for the last frame.

Behaviour:
- Reset: all slots cfg_valid=0, offsets 0, direction +, last-step 0, sync flops 0. Every output 0 on the cycle after Reset is sampled.
- frame_clk handling:
  - Passes through a 2-flop synchroniser plus rising-edge detect, giving a one-Clk frame_tick.
  - frame_tick fires 3 Clk after the frame_clk rise.
  - A frame_clk that stays high yields exactly one tick.
- Per-slot state: base X/Y, mode, range, speed, signed 11-bit offset, direction bit, signed last-step.
- Current centre = base + offset on the patrol axis. The other axis equals its base.
- On frame_tick, for each valid moving slot:
  - next = offset ± speed, following the direction bit.
  - If |next| ≥ range: offset clamps to ±range, direction flips, and last-step = the actual clamped delta.
  - Otherwise offset = next and last-step = ±speed.
- Static, reserved or invalid slots: offset holds 0 and last-step = 0.
- range = 0 or speed = 0: the ledge never moves and last-step = 0.
- Config write:
  - Takes effect next cycle. Loads all fields, clears offset to 0, sets direction +, last-step 0.
  - A write and a frame_tick in the same cycle: the write wins for that slot; other slots still step.
  - cfg_idx ≥ NUM_LEDGES: the write is ignored.
- Bounds per slot, saturating in 10 bits:
  - left = X − HALF_W, floored at 0.
  - right = X + HALF_W, capped at 1023.
  - top and bottom use the same rule with HALF_H.
  - Comparisons are inclusive.
- Draw hit:
  - is_ledge and ledge_idx are registered, 1-cycle latency from DrawX/DrawY.
  - Lowest valid index wins. With no hit, ledge_idx = 0.
- Landing:
  - Registered, 1-cycle latency.
  - Hit requires left ≤ query_x ≤ right and top ≤ query_y ≤ top + LAND_TOL (saturating).
  - Lowest index wins. land_top_y = top; land_dx/land_dy = that slot's last-step on its patrol axis, 0 on the other.
  - No hit: land_hit = 0, land_top_y = 0, land_dx = land_dy = 0.
- Positions used by the hit logic are the registered values, so a frame step becomes visible to draw/landing one cycle after frame_tick.

Test Plan:
- Reset, then write slot0 valid static x=320 y=400; sweep DrawY=400 → is_ledge=1 for DrawX 253..387, 0 at 252/388, ledge_idx=0, one cycle late.
- Write slot1 horizontal, x=200, range=10, speed=4; send 5 frame_clk pulses → centre X 204, 208, 210 (clamped, direction flips), 206, 202; last-step +4, +4, +2, −4, −4.
- Overlap slot0 and slot2 at pixel (320,400) → ledge_idx=0. Disable slot0 → ledge_idx=2.
- Query (320,388) and (320,392) → land_hit=1, land_top_y=388. Query (320,393) and (320,387) → land_hit=0.
- Slot at x=30 → left bound saturates to 0 and DrawX=0 hits. Slot at x=1000 → right bound = 1023, no wrap to low X.
- Config write to slot1 coincident with frame_tick → slot1 offset 0, direction +; slot3 (moving) still steps. Assert Reset mid-patrol → all outputs 0, all slots invalid.
